aes_round_router: RTL

//   Parametrised, registered 1-to-N router that generalises the 1-to-9 demux of the cipher unit.

---
 rtl/aes_round_router.sv | 115 +++++++++++
 1 files changed

// File: rtl/aes_round_router.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_router
// Description : Registered 1-to-N router for round state / key words. Each
//               accepted word goes to exactly one of N_OUT round-stage
//               consumers. The destination is either an explicit select
//               (mode=0) or an internal round counter that advances on every
//               accepted mode-1 word. All channels use valid/ready flow
//               control through a single one-entry output register.
// Ports       :
//   clk, rst           clock, synchronous active-high reset
//   mode               0 = explicit select, 1 = auto round sequence
//   in_sel             destination channel (mode 0 only)
//   in_data/valid/ready  upstream handshake
//   seq_clr            clear round counter (wins over an increment)
//   out_data           shared registered output bus
//   out_valid          one-hot channel valid
//   out_ready          per-channel consumer ready
//   rnd_cnt            current round counter
//   seq_last           held word is the last round of a sequence
//   err                one-cycle pulse when an out-of-range select is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_router #(
    parameter int DATA_W = 128,
    parameter int N_OUT  = 11,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              seq_clr,
    output logic [DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]  out_valid,
    input  logic [N_OUT-1:0]  out_ready,
    output logic [SEL_W-1:0]  rnd_cnt,
    output logic              seq_last,
    output logic              err
);

    localparam logic [SEL_W-1:0] c_LAST_CH  = SEL_W'(N_OUT - 1);
    // One bit wider than the select so N_OUT itself is representable
    // (N_OUT=16 with SEL_W=4).
    localparam logic [SEL_W:0]   c_N_OUT_EXT = (SEL_W + 1)'(N_OUT);

    logic [DATA_W-1:0] r_out_data;
    logic [N_OUT-1:0]  r_out_valid;
    logic [SEL_W-1:0]  r_rnd_cnt;
    logic              r_seq_last;
    logic              r_err;

    logic              w_drain;
    logic              w_in_ready;
    logic              w_accept;
    logic [SEL_W-1:0]  w_ch;
    logic              w_in_range;
    logic [N_OUT-1:0]  w_onehot;
    logic              w_cnt_last;

    // Ready bits of idle channels are masked by out_valid, so they cannot
    // cause a spurious drain.
    assign w_drain    = |(r_out_valid & out_ready);
    // One-entry pipeline: accept when empty or when the held word leaves now.
    assign w_in_ready = ~(|r_out_valid) | w_drain;
    assign w_accept   = in_valid & w_in_ready;
    assign w_ch       = mode ? r_rnd_cnt : in_sel;
    assign w_in_range = ({1'b0, w_ch} < c_N_OUT_EXT);
    assign w_onehot   = {{(N_OUT-1){1'b0}}, 1'b1} << w_ch;
    assign w_cnt_last = (r_rnd_cnt == c_LAST_CH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= '0;
            r_rnd_cnt   <= '0;
            r_seq_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Output register: load on a routed accept, clear on a plain
            // drain, otherwise hold. A dropped (out-of-range) accept can only
            // happen when empty or draining, so clearing covers that case.
            if (w_accept && w_in_range) begin
                r_out_data  <= in_data;
                r_out_valid <= w_onehot;
                r_seq_last  <= mode & w_cnt_last;
            end else if (w_drain) begin
                r_out_valid <= '0;
                r_seq_last  <= 1'b0;
            end

            r_err <= w_accept & ~w_in_range;

            // Clear wins over increment; a word accepted alongside the clear
            // has already been routed with the pre-clear count above.
            if (seq_clr) begin
                r_rnd_cnt <= '0;
            end else if (w_accept && mode) begin
                r_rnd_cnt <= w_cnt_last ? '0 : r_rnd_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign rnd_cnt   = r_rnd_cnt;
    assign seq_last  = r_seq_last;
    assign err       = r_err;

endmodule
`default_nettype wire
